// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// State encodings, opcodes, ALUOp/mux encodings and the control bundle.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_DONE    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_DONE = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state -> datapath control vector (Moore, FETCH uses mem_ready).
// Ports: i_state, i_mem_ready in; o_ctrl out (ctrl_t bundle).
module control_output_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        // IR and PC update only when the fetch completes
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.ior_d     = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_DONE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_DONE: begin
        o_ctrl.reg_write = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with illegal-opcode trap.
// Ports: clk, rst_n, opcode, mem_ready in; datapath controls, illegal, state, retired out.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int EN_ADDI = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ior_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  ctrl_t            w_dec;
  ctrl_t            w_ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      unique case (r_state)
        S_FETCH:
          if (mem_ready) r_state <= S_DECODE;
        S_DECODE:
          unique case (1'b1)
            opcode == OP_RTYPE:
              r_state <= S_EXEC;
            (opcode == OP_LW) || (opcode == OP_SW):
              r_state <= S_MEM_ADDR;
            opcode == OP_BEQ:
              r_state <= S_BRANCH;
            opcode == OP_J:
              r_state <= S_JUMP;
            (opcode == OP_ADDI) && (EN_ADDI != 0):
              r_state <= S_ADDI_EXEC;
            default:
              r_state <= S_TRAP;
          endcase
        S_MEM_ADDR:
          r_state <= (opcode == OP_SW) ? S_MEM_WRITE
                                       : S_MEM_READ;
        S_MEM_READ:
          if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE:
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + ONE;
          end
        S_EXEC:
          r_state <= S_R_DONE;
        S_ADDI_EXEC:
          r_state <= S_ADDI_DONE;
        S_MEM_WB, S_R_DONE, S_BRANCH,
        S_JUMP, S_ADDI_DONE: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + ONE;
        end
        S_TRAP:
          r_illegal <= 1'b1;
        default:
          r_state <= S_FETCH;
      endcase
    end
  end

  control_output_decode u_dec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_dec)
  );

  // No datapath write may escape during a reset cycle
  assign w_ctrl = rst_n ? w_dec : '0;

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign ior_d         = w_ctrl.ior_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign ir_write      = w_ctrl.ir_write;
  assign reg_write     = w_ctrl.reg_write;
  assign reg_dst       = w_ctrl.reg_dst;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign pc_source     = w_ctrl.pc_source;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign illegal       = r_illegal;
  assign state         = r_state;
  assign retired       = r_retired;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the instruction opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = use the funct field.
- Stalls on memory, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- EN_ADDI, 1: when 1, opcode 001000 (addi) is legal; when 0, it traps as illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset; one clock, synchronous, active-low reset.
- opcode  in  6  instruction bits [31:26] from the IR.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, ior_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a  out  1 each  datapath controls.
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  to the ALU control decoder.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: while rst_n=0 at a clock edge, state <= FETCH, illegal <= 0, retired <= 0.
- Reset gating: all control outputs are forced to 0 combinationally while rst_n=0. This overrides mid-instruction state; no write may occur in a reset cycle.
- Output style: outputs are Moore (decoded from state). Exception: in FETCH, ir_write and pc_write equal mem_ready.
- Default: any control not listed for a state is 0.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, R_DONE=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_DONE=11, TRAP=12.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, ir_write=pc_write=mem_ready. mem_ready=1 -> DECODE; else hold.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC if EN_ADDI, else TRAP
  - any other opcode -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, ior_d=1. Hold until mem_ready=1, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WRITE: mem_write=1, ior_d=1. Hold until mem_ready=1, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_DONE.
- R_DONE: reg_write=1, reg_dst=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_DONE.
- ADDI_DONE: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- TRAP: illegal <= 1. All controls 0. Stays in TRAP until reset.
- Retire counting: retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_DONE, BRANCH, JUMP or ADDI_DONE. It wraps from all-ones to 0.
- Latency: R-type 4 cycles, lw 5, sw 4, beq/j 3, addi 4, each plus memory stall cycles.
- opcode is sampled only in DECODE and MEM_ADDR; it is a don't-care elsewhere.
- Unused encodings 13-15 -> FETCH next cycle with all controls 0 (defensive).

Decomposition:
- Shared package holds:
  - state localparams
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - pc_source and alu_src_b encodings
- One sub-module, control_output_decode: purely combinational state -> control-vector mapping, reused by the bench as a reference model.
- Next-state logic, the illegal flag and the retired counter stay in the top.

Test Plan:
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXEC; reg_write=reg_dst=1 in R_DONE; retired=1.
- lw with stall: opcode=100011, mem_ready low for 2 cycles in MEM_READ -> MEM_READ held 3 cycles with ior_d=1; then MEM_WB with mem_to_reg=1; total 7 cycles.
- beq then j back-to-back -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01. JUMP: pc_write=1, pc_source=10. Afterwards retired=2.
- Illegal opcode 111111 -> TRAP (state=12); illegal=1 held for 10+ cycles with all controls 0; mem_ready toggling has no effect.
- Reset mid-instruction: rst_n=0 during MEM_WRITE -> mem_write=0 in that same cycle; after release state=0, illegal=0, retired=0.
- Counter wrap: CNT_W=4, 16 J instructions -> retired returns to 0. EN_ADDI=0 with opcode 001000 -> TRAP.
